// File: rtl/ads1115_scan.sv
// ADS1115 scanner: I2C master that configures, waits for, and reads back
// each single-ended channel in turn, publishing one result per channel.
module ads1115_scan #(
   parameter int unsigned CLK_DIV   = 125,
   parameter logic [6:0]  DEV_ADDR  = 7'b1001000,
   parameter int unsigned NUM_CH    = 4,
   parameter logic [2:0]  PGA       = 3'b001,
   parameter logic [2:0]  DR        = 3'b100,
   parameter int unsigned CONV_WAIT = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        SCL,
   inout  wire         SDA,
   output logic [15:0] data,
   output logic [1:0]  data_ch,
   output logic        data_valid,
   output logic        busy,
   output logic        nack_err
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [31:0] WAIT_LAST = 32'(CONV_WAIT - 1);
   localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

   typedef enum logic [2:0] {IDLE, CFG, WAIT_CONV, PTR, READ, NEXT} state_t;
   typedef enum logic [1:0] {PH_START, PH_BIT, PH_STOP} phase_t;

   state_t           state, state_n;
   phase_t           phase;
   logic [DIV_W-1:0] div;
   logic [1:0]       q;
   logic [3:0]       bit_idx;
   logic [1:0]       byte_idx;
   logic [31:0]      wait_cnt;
   logic [1:0]       ch;
   logic [15:0]      rx;
   logic             got_nack;
   logic             lsb_done;
   logic             sda_low;
   logic             sda_in;
   logic [7:0]       tx_byte;
   logic             tick, in_xfer, rd_byte, last_byte, txn_end;

   assign SDA     = sda_low ? 1'b0 : 1'bz;
   assign sda_in  = SDA;
   assign busy    = (state != IDLE);
   assign tick    = (div == DIV_LAST);
   assign in_xfer = (state == CFG) || (state == PTR) || (state == READ);
   assign rd_byte = (state == READ) && (byte_idx != 2'd0);
   assign txn_end = in_xfer && (phase == PH_STOP) && tick && (q == 2'd2);

   always_comb begin
      last_byte = 1'b0;
      unique case (state)
         CFG:     last_byte = (byte_idx == 2'd3);
         PTR:     last_byte = (byte_idx == 2'd1);
         READ:    last_byte = (byte_idx == 2'd2);
         default: last_byte = 1'b0;
      endcase
   end

   always_comb begin
      tx_byte = {DEV_ADDR, state == READ};
      unique case (byte_idx)
         2'd1:    tx_byte = (state == CFG) ? 8'h01 : 8'h00;
         2'd2:    tx_byte = {2'b11, ch, PGA, 1'b1};
         2'd3:    tx_byte = {DR, 5'b00011};
         default: tx_byte = {DEV_ADDR, state == READ};
      endcase
   end

   // Bus levels decode from registered sequencer state, so SDA only moves
   // on the edge that starts a quarter.
   always_comb begin
      SCL     = 1'b1;
      sda_low = 1'b0;
      if (in_xfer) begin
         unique case (phase)
            PH_START: sda_low = q[0];
            PH_BIT: begin
               SCL = q[1];
               if (bit_idx == 4'd8)
                  sda_low = rd_byte && !last_byte;
               else
                  sda_low = !rd_byte && !tx_byte[3'd7 - bit_idx[2:0]];
            end
            PH_STOP: begin
               SCL     = (q != 2'd0);
               sda_low = (q != 2'd2);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (run) state_n = CFG;
         CFG:       if (txn_end) state_n = got_nack ? NEXT : WAIT_CONV;
         WAIT_CONV: if (wait_cnt == WAIT_LAST) state_n = PTR;
         PTR:       if (txn_end) state_n = got_nack ? NEXT : READ;
         READ:      if (txn_end) state_n = NEXT;
         NEXT:      state_n = (ch != LAST_CH || run) ? CFG : IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase      <= PH_START;
         div        <= '0;
         q          <= 2'd0;
         bit_idx    <= 4'd0;
         byte_idx   <= 2'd0;
         wait_cnt   <= 32'd0;
         ch         <= 2'd0;
         rx         <= 16'd0;
         got_nack   <= 1'b0;
         lsb_done   <= 1'b0;
         data       <= 16'd0;
         data_ch    <= 2'd0;
         data_valid <= 1'b0;
         nack_err   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         lsb_done   <= 1'b0;
         if (lsb_done) begin
            data       <= rx;
            data_ch    <= ch;
            data_valid <= 1'b1;
         end
         if (state == IDLE && run) begin
            nack_err <= 1'b0;
            ch       <= 2'd0;
         end
         if (state == NEXT)
            ch <= (ch == LAST_CH) ? 2'd0 : ch + 2'd1;
         wait_cnt <= (state == WAIT_CONV) ? wait_cnt + 32'd1 : 32'd0;
         if (!in_xfer || txn_end) begin
            phase    <= PH_START;
            div      <= '0;
            q        <= 2'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
            if (!in_xfer) got_nack <= 1'b0;
         end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
               q <= q + 2'd1;
               unique case (phase)
                  PH_START: if (q == 2'd1) begin
                     phase <= PH_BIT;
                     q     <= 2'd0;
                  end
                  PH_BIT: begin
                     if (q == 2'd2) begin
                        if (bit_idx == 4'd8) begin
                           if (!rd_byte && sda_in) begin
                              got_nack <= 1'b1;
                              nack_err <= 1'b1;
                           end
                        end else if (rd_byte) begin
                           rx       <= {rx[14:0], sda_in};
                           lsb_done <= last_byte && (bit_idx == 4'd7);
                        end
                     end
                     if (q == 2'd3) begin
                        if (bit_idx == 4'd8) begin
                           bit_idx <= 4'd0;
                           if (got_nack || last_byte) begin
                              phase <= PH_STOP;
                              q     <= 2'd0;
                           end else begin
                              byte_idx <= byte_idx + 2'd1;
                           end
                        end else begin
                           bit_idx <= bit_idx + 4'd1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ads1115_scan.sv
// Bench for ads1115_scan: behavioural ADS1115 slave on the bus plus a
// per-sweep expected-result queue built from the channel values.
module tb_ads1115_scan;

   localparam logic [6:0] ADDR = 7'h48;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        scl;
   wire         sda;
   logic [15:0] data;
   logic [1:0]  data_ch;
   logic        data_valid, busy, nack_err;

   int checks = 0;
   int errors = 0;

   logic        s_drive = 1'b0;
   logic        pscl = 1'b1, psda = 1'b1;
   logic        s_act = 1'b0, s_rw = 1'b0, s_ack = 1'b0;
   int          s_bit = 0, s_byte = 0;
   logic [7:0]  s_sh = 8'd0;
   logic [7:0]  wb[4];
   logic [1:0]  s_ch = 2'd0;
   logic [23:0] cfg_seen[4];
   logic        mack[2];
   logic [15:0] val[4];
   int          addr_cnt = 0;
   int          nack_at = -1;
   logic        trig = 1'b0;

   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   assign sda = (s_drive && !rst) ? 1'b0 : 1'bz;
   pullup (sda);

   ads1115_scan #(
      .CLK_DIV(2), .DEV_ADDR(ADDR), .NUM_CH(4),
      .PGA(3'b001), .DR(3'b100), .CONV_WAIT(20)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .SCL(scl), .SDA(sda),
      .data(data), .data_ch(data_ch), .data_valid(data_valid),
      .busy(busy), .nack_err(nack_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (data_valid) got_q.push_back(32'({data_ch, data}));

   // Slave watches the bus on the falling system clock edge.
   always @(negedge clk) begin
      logic       cs, cd;
      logic [7:0] cur;
      cs = scl;
      cd = sda;
      if (rst) begin
         s_act   = 1'b0;
         s_drive = 1'b0;
      end else if (pscl && cs && psda && !cd) begin
         s_act = 1'b1; s_bit = 0; s_byte = 0; s_drive = 1'b0;
      end else if (pscl && cs && !psda && cd) begin
         if (s_act && !s_rw && s_byte == 4 && wb[1] == 8'h01) begin
            s_ch = wb[2][5:4];
            cfg_seen[s_ch] = {wb[1], wb[2], wb[3]};
         end
         s_act = 1'b0; s_drive = 1'b0;
      end else if (s_act && !pscl && cs) begin
         if (s_bit < 8) begin
            s_sh = {s_sh[6:0], cd};
            s_bit++;
            if (s_bit == 8) begin
               if (s_byte == 0) begin
                  s_rw  = s_sh[0];
                  s_ack = (s_sh[7:1] == ADDR) && (addr_cnt != nack_at);
                  addr_cnt++;
               end
               if (!s_rw && s_byte < 4) wb[s_byte] = s_sh;
            end
         end else begin
            if (s_rw && s_byte > 0) begin
               if (s_byte < 3) mack[s_byte-1] = cd;
               if (cd) s_act = 1'b0;
            end else if (!s_ack) begin
               s_act = 1'b0;
            end
            s_bit = 0;
            s_byte++;
         end
      end else if (s_act && pscl && !cs) begin
         if (s_bit == 8) begin
            s_drive = s_ack && (!s_rw || s_byte == 0);
         end else if (s_rw && (s_byte == 1 || s_byte == 2)) begin
            cur = (s_byte == 1) ? val[s_ch][15:8] : val[s_ch][7:0];
            s_drive = !cur[7 - s_bit];
            if (s_byte == 1 && s_bit == 3) trig = 1'b1;
         end else begin
            s_drive = 1'b0;
         end
      end
      pscl = cs;
      psda = cd;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic wait_cnt(input int n, input int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("valid_cnt", 32'(got_q.size()), 32'(n));
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle", 32'(busy), 32'd0);
   endtask

   task automatic cmp_q(input string tag);
      check({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check(tag, (i < got_q.size()) ? got_q[i] : 32'hdead, exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic bus_idle(input string tag);
      check({tag, "_scl"}, 32'(scl), 32'd1);
      check({tag, "_sda"}, 32'(sda), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_sweep(input int nk, input string tag);
      for (int c = 0; c < 4; c++)
         if (c != nk) exp_q.push_back(32'({2'(c), val[c]}));
      nack_at = (nk < 4) ? addr_cnt + 3 * nk : -1;
      mack[0] = 1'b1;
      mack[1] = 1'b0;
      @(negedge clk) run = 1'b1;
      @(negedge clk) run = 1'b0;
      check({tag, "_nclr"}, 32'(nack_err), 32'd0);
      check({tag, "_start"}, 32'(busy), 32'd1);
      wait_idle(8000);
      cmp_q(tag);
      check({tag, "_nack"}, 32'(nack_err), 32'(nk < 4));
      bus_idle(tag);
      if (nk != 3) begin
         check({tag, "_mack"}, 32'(mack[0]), 32'd0);
         check({tag, "_mnak"}, 32'(mack[1]), 32'd1);
      end
      nack_at = -1;
   endtask

   initial begin
      int k;
      for (int c = 0; c < 4; c++) begin
         val[c]      = 16'h1234 + 16'(c);
         cfg_seen[c] = 24'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_data", 32'(data), 32'd0);
      check("rst_ch", 32'(data_ch), 32'd0);
      check("rst_dv", 32'(data_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_nack", 32'(nack_err), 32'd0);
      @(negedge clk) rst = 1'b0;

      // continuous scan, then drop run just after the wrap to ch0
      for (int c = 0; c < 4; c++) exp_q.push_back(32'({2'(c), val[c]}));
      exp_q.push_back(32'({2'd0, val[0]}));
      @(negedge clk) run = 1'b1;
      wait_cnt(5, 20000);
      run = 1'b0;
      for (int c = 1; c < 4; c++) exp_q.push_back(32'({2'(c), val[c]}));
      wait_idle(8000);
      cmp_q("cont");
      bus_idle("cont");
      check("cfg_ch2", 32'(cfg_seen[2]), 32'h0001e383);
      check("cfg_ch0", 32'(cfg_seen[0]), 32'h0001c383);
      check("mack_msb", 32'(mack[0]), 32'd0);
      check("mack_lsb", 32'(mack[1]), 32'd1);

      // NACK on ch1 address, then a clean sweep with a negative full-scale
      for (int c = 0; c < 4; c++) val[c] = 16'($urandom);
      run_sweep(1, "nack1");
      for (int c = 0; c < 3; c++) val[c] = 16'($urandom);
      val[3] = 16'h8000;
      run_sweep(4, "neg");

      for (int it = 0; it < 3; it++) begin
         for (int c = 0; c < 4; c++) val[c] = 16'($urandom);
         run_sweep(int'($urandom_range(0, 4)), "rand");
      end

      // reset in the middle of the first read
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      trig = 1'b0;
      @(negedge clk) run = 1'b1;
      k = 0;
      while (!trig && k < 8000) begin
         @(negedge clk);
         k++;
      end
      check("trig", 32'(trig), 32'd1);
      rst = 1'b1;
      run = 1'b0;
      @(posedge clk);
      #1;
      bus_idle("abort");
      check("abort_data", 32'(data), 32'd0);
      check("abort_dv", 32'(data_valid), 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_noval", 32'(got_q.size()), 32'd0);
      got_q.delete();
      run_sweep(4, "restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ads1115_scan.md
ADS1115_SCAN -- requirements
Module: ads1115_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125, meaning clk cycles per quarter SCL period (SCL = f_clk/(4*CLK_DIV), 100 kHz at 50 MHz).
REQ-002 The block SHALL have parameter DEV_ADDR, default 7'b1001000, meaning the 7-bit I2C slave address.
REQ-003 The block SHALL have parameter NUM_CH, default 4, legal 1..4, meaning single-ended channels scanned, AIN0 upward.
REQ-004 The block SHALL have parameter PGA, default 3'b001, meaning the config PGA field.
REQ-005 The block SHALL have parameter DR, default 3'b100, meaning the config DR field.
REQ-006 The block SHALL have parameter CONV_WAIT, default 500000, meaning clk cycles between config STOP and pointer START.
REQ-007 The block SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-008 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-009 The block SHALL have port run  input  1  level; high = scan continuously.
REQ-010 The block SHALL have port SCL  output  1  I2C clock, push-pull.
REQ-011 The block SHALL have port SDA  inout  1  I2C data, open-drain (drives 0 or Z only).
REQ-012 The block SHALL have port data  output  16  last conversion result, two's complement.
REQ-013 The block SHALL have port data_ch  output  2  channel of data.
REQ-014 The block SHALL have port data_valid  output  1  one-clk pulse when data/data_ch update.
REQ-015 The block SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-016 The block SHALL have port nack_err  output  1  sticky NACK flag.

Function
REQ-017 Top-level FSM states SHALL be IDLE, CFG, WAIT_CONV, PTR, READ, NEXT.
- Transitions: IDLE->CFG when run=1, ch=0.
- CFG->WAIT_CONV.
- WAIT_CONV->PTR after CONV_WAIT cycles.
- PTR->READ.
- READ->NEXT.
- NEXT->CFG with ch+1, or with ch=0 after NUM_CH-1 if run=1, else IDLE.
REQ-018 CFG SHALL send START, {DEV_ADDR,0}, 8'h01, {1'b1,1'b1,ch[1:0],PGA,1'b1}, {DR,5'b00011}, then STOP.
REQ-019 PTR SHALL send START, {DEV_ADDR,0}, 8'h00, then STOP.
REQ-020 READ SHALL send START and {DEV_ADDR,1}, receive MSB (master ACK) and LSB (master NACK), then STOP.
REQ-021 Bit timing SHALL follow these rules:
- Each bit spans 4 quarters: SCL low, low, high, high.
- SDA changes only at the start of the first low quarter.
- SDA is sampled at the end of the first high quarter.
REQ-022 START SHALL be SDA 1->0 with SCL high; STOP SHALL be SDA 0->1 with SCL high; at least one quarter SHALL separate STOP and the next START.
REQ-023 The block SHALL release SDA during the slave ACK bit and both received bytes; a sampled 1 on ACK is a NACK.
REQ-024 On NACK the block SHALL issue STOP, set nack_err, skip remaining phases of that channel, not pulse data_valid, and go to NEXT.
REQ-025 nack_err SHALL clear only on rst or on the IDLE->CFG transition.
REQ-026 data, data_ch, and data_valid SHALL update in the same cycle, one clk after the LSB sample.
REQ-027 Deasserting run mid-sweep SHALL finish the current sweep through channel NUM_CH-1 before entering IDLE.
REQ-028 In IDLE, SCL SHALL be 1 and SDA SHALL be released.
REQ-029 Channel wrap SHALL be NUM_CH-1 -> 0; NUM_CH=1 SHALL repeatedly scan AIN0 only.

Reset
REQ-030 On rst the block SHALL reset as follows:
- FSM to IDLE.
- SCL=1, SDA released.
- data=0, data_ch=0, data_valid=0, busy=0, nack_err=0.
- All counters to 0.
REQ-031 rst mid-transfer SHALL abort immediately without generating STOP; recovery SHALL be the next START after run.

Verification
Use an ADS1115 slave model, CLK_DIV=2, CONV_WAIT=20.
REQ-032 NUM_CH=4, run held 1, slave returns 16'h1234+ch -> four data_valid pulses with data_ch 0,1,2,3 and data 1234,1235,1236,1237, then channel 0 again.
REQ-033 Config bytes captured by the model for ch2 SHALL be 01, E3, 83 (PGA=001, DR=100).
REQ-034 Slave NACKs address on ch1 only -> nack_err=1, no data_valid for ch1, ch2 result still delivered.
REQ-035 run pulsed 1 for one cycle -> exactly one sweep (NUM_CH pulses), then busy=0, SCL=1, SDA=Z.
REQ-036 rst asserted during READ MSB bit 3 -> next cycle SCL=1, SDA=Z, busy=0, data unchanged from 0; a following run restarts at ch0.
REQ-037 Slave returns 16'h8000 -> data=16'h8000 (no sign alteration); master ACK on MSB is 0, on LSB is released (1).
